// File: rtl/imem_stream_loader_if.sv
// Bundle of the loader's control, byte-stream and instruction-memory write signals.
// The loader uses the slave view; the controlling agent uses the master view.
interface imem_stream_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err,
           words_loaded
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err,
           words_loaded
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Instruction-memory loader: takes a byte stream (16-bit BE word count, then BE words),
// writes words 0..N-1 and holds the CPU until a load completes.
module imem_stream_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input logic                 clock,
  input logic                 reset_n,
  imem_stream_loader_if.slave bus
);
  typedef enum logic [2:0] {StIdle, StLenHi, StLenLo, StData, StDone, StErr} state_e;

  state_e            r_state, w_state_nxt;
  logic [15:0]       r_len, w_len_nxt;
  logic [1:0]        r_bcnt, w_bcnt_nxt;
  logic [23:0]       r_part, w_part_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              r_hold, w_hold_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [ADDR_W:0]   r_cnt, w_cnt_nxt;
  logic              w_hs, w_in_ready, w_last_wr;
  logic [15:0]       w_len_full;

  // The final word's write cycle must not swallow a stray byte beyond the stream.
  assign w_last_wr  = r_we && (32'(r_cnt) == 32'(r_len));
  assign w_in_ready = (r_state == StLenHi) || (r_state == StLenLo) ||
                      ((r_state == StData) && !w_last_wr);
  assign w_hs       = bus.in_valid && w_in_ready;
  assign w_len_full = {r_len[15:8], bus.in_data};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_bcnt  <= '0;
      r_part  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_part  <= w_part_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_hold  <= w_hold_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_bcnt_nxt  = r_bcnt;
    w_part_nxt  = r_part;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_hold_nxt  = r_hold;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      StIdle, StDone, StErr: begin
        if (bus.start) begin
          w_state_nxt = StLenHi;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_hold_nxt  = 1'b1;
          w_bcnt_nxt  = '0;
        end
      end
      StLenHi: begin
        if (w_hs) begin
          w_len_nxt   = {bus.in_data, r_len[7:0]};
          w_state_nxt = StLenLo;
        end
      end
      StLenLo: begin
        if (w_hs) begin
          w_len_nxt = w_len_full;
          if (w_len_full == 16'd0) begin
            w_state_nxt = StDone;
            w_done_nxt  = 1'b1;
            w_hold_nxt  = 1'b0;
          end else if (32'(w_len_full) > DEPTH) begin
            w_state_nxt = StErr;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = StData;
            w_bcnt_nxt  = '0;
          end
        end
      end
      StData: begin
        if (w_last_wr) begin
          w_state_nxt = StDone;
          w_done_nxt  = 1'b1;
          w_hold_nxt  = 1'b0;
        end else if (w_hs) begin
          w_part_nxt = {r_part[15:0], bus.in_data};
          w_bcnt_nxt = r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_cnt[ADDR_W-1:0];
            w_wdata_nxt = {r_part, bus.in_data};
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.imem_we      = r_we;
  assign bus.imem_addr    = r_addr;
  assign bus.imem_wdata   = r_wdata;
  assign bus.cpu_hold     = r_hold;
  assign bus.load_done    = r_done;
  assign bus.load_err     = r_err;
  assign bus.words_loaded = r_cnt;
endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench for imem_stream_loader: scoreboard of expected memory writes, popped by a monitor.
module tb_imem_stream_loader;
  logic clock;
  logic reset_n;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [41:0] exp_q[$];

  imem_stream_loader_if #(.ADDR_W(10)) bus ();

  imem_stream_loader #(
    .ADDR_W (10),
    .DEPTH  (1024)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every write must match the oldest outstanding expected word.
  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", 32'(bus.imem_we), 32'd0);
      end else begin
        logic [41:0] e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(bus.imem_addr), 32'(e[41:32]));
        check_eq("wr_data", bus.imem_wdata, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check_eq("ready_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [9:0] addr, input logic [31:0] w, input int gap_max,
                           input bit poke);
    exp_q.push_back({addr, w});
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[31-8*i -: 8];
      if (poke && i == 1) bus.start = 1'b1;
      send_byte(b, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
      bus.start = 1'b0;
    end
    check_eq("we_latency", 32'(bus.imem_we), 32'd1);
  endtask

  task automatic run_load(input int gap_max, input bit poke);
    pulse_start();
    check_eq("hold_loading", 32'(bus.cpu_hold), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(10'd0, 32'h2008_0005, gap_max, poke);
    send_word(10'd1, 32'h3109_0003, gap_max, poke);
    check_eq("ready_last_wr", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    check_eq("done_pulse", 32'(bus.load_done), 32'd1);
    check_eq("hold_rel", 32'(bus.cpu_hold), 32'd0);
    check_eq("ready_done", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    check_eq("done_one_cyc", 32'(bus.load_done), 32'd0);
    check_eq("hold_stays0", 32'(bus.cpu_hold), 32'd0);
    check_eq("words_loaded", 32'(bus.words_loaded), 32'd2);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    check_eq({tag, "_we"}, 32'(bus.imem_we), 32'd0);
    check_eq({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
    check_eq({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    check_eq({tag, "_hold"}, 32'(bus.cpu_hold), 32'd1);
    check_eq({tag, "_done"}, 32'(bus.load_done), 32'd0);
    check_eq({tag, "_err"}, 32'(bus.load_err), 32'd0);
    check_eq({tag, "_cnt"}, 32'(bus.words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    reset_n = 1'b1;

    // Idle after reset: CPU held, nothing accepted, nothing written.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_eq("idle_hold", 32'(bus.cpu_hold), 32'd1);
      check_eq("idle_ready", 32'(bus.in_ready), 32'd0);
      check_eq("idle_we", 32'(bus.imem_we), 32'd0);
    end
    bus.in_valid = 1'b0;

    run_load(0, 1'b0);
    run_load(3, 1'b0);

    // Oversized count goes to the error state and writes nothing.
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check_eq("err_flag", 32'(bus.load_err), 32'd1);
    check_eq("err_hold", 32'(bus.cpu_hold), 32'd1);
    check_eq("err_ready", 32'(bus.in_ready), 32'd0);
    repeat (5) @(negedge clock);
    check_eq("err_sticky", 32'(bus.load_err), 32'd1);
    pulse_start();
    check_eq("err_cleared", 32'(bus.load_err), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_eq("zero_done", 32'(bus.load_done), 32'd1);
    check_eq("zero_hold", 32'(bus.cpu_hold), 32'd0);
    check_eq("zero_cnt", 32'(bus.words_loaded), 32'd0);

    // Reset mid-load: word 0 lands, word 1 never does.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(10'd0, 32'h2008_0005, 0, 1'b0);
    send_byte(8'h31, 0);
    send_byte(8'h09, 0);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clock);
    check_eq("midrst_q", 32'(exp_q.size()), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    run_load(0, 1'b0);

    // Start pulses while streaming are ignored.
    run_load(1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
